// File: rtl/uart_cmd_parser.sv
// Byte-level command parser between the UART receiver and transmitter.
// It decodes {SYNC, CMD, ARG, CHK} frames, drives the LED register and returns a 1-byte reply.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 104160,
  parameter logic [7:0]  LED_RESET    = 8'h00,
  parameter logic [7:0]  ACK_BYTE     = 8'h06,
  parameter logic [7:0]  NAK_BYTE     = 8'h15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] led,
  output logic       err
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] CmdWrite = 8'h01;
  localparam logic [7:0] CmdRead  = 8'h02;

  typedef enum logic [2:0] {StIdle, StGetCmd, StGetArg, StGetChk, StReply} state_e;

  state_e            state_q;
  logic [7:0]        cmd_q;
  logic [7:0]        arg_q;
  logic [TimerW-1:0] timer_q;
  logic              chk_ok;

  assign chk_ok = (rx_data == (cmd_q ^ arg_q));

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= StIdle;
      cmd_q    <= 8'h00;
      arg_q    <= 8'h00;
      timer_q  <= '0;
      led      <= LED_RESET;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state_q)
        StIdle: begin
          timer_q <= '0;
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state_q <= StGetCmd;
          end
        end
        StGetCmd, StGetArg, StGetChk: begin
          if (rx_valid) begin
            // A byte arriving in the expiry cycle still wins.
            timer_q <= '0;
            case (state_q)
              StGetCmd: begin
                cmd_q   <= rx_data;
                state_q <= StGetArg;
              end
              StGetArg: begin
                arg_q   <= rx_data;
                state_q <= StGetChk;
              end
              default: begin
                state_q  <= StReply;
                tx_valid <= 1'b1;
                if (chk_ok && cmd_q == CmdWrite) begin
                  led     <= arg_q;
                  tx_data <= ACK_BYTE;
                end else if (chk_ok && cmd_q == CmdRead) begin
                  tx_data <= led;
                end else begin
                  tx_data <= NAK_BYTE;
                  err     <= 1'b1;
                end
              end
            endcase
          end else if (timer_q >= TimerLast) begin
            state_q <= StIdle;
            timer_q <= '0;
            err     <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StReply: begin
          // Bytes received while a reply is pending are dropped.
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: begin
          state_q  <= StIdle;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
